// File: rtl/uart_io_responder.sv
// uart_io_responder
//   Responder for the exec stage's UART IN/OUT request interface. Received bytes are
//   buffered in an RX FIFO; an IN request pops 1-4 bytes (first byte most significant,
//   upper bits zero) and returns them as a word. An OUT request serializes the low 1-4
//   bytes of a word, most significant selected byte first, to the byte transmitter.
//
//   Optional feature macro: UART_IO_LOOPBACK_EN
//     defined   - every transmitted byte (tx handshake) is pushed into the RX FIFO and
//                 rx_byte/rx_valid are ignored.
//     undefined - the RX FIFO is fed only by rx_byte/rx_valid.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   uart_renable, uart_rsz     IN request strobe, size code (bytes = rsz+1)
//   uart_rd, uart_rdone        assembled IN word, one-cycle IN completion pulse
//   uart_wenable, uart_wsz     OUT request strobe, size code (bytes = wsz+1)
//   uart_wd, uart_wdone        OUT word (sampled with strobe), one-cycle OUT completion
//   rx_byte, rx_valid          byte from uart_rx
//   tx_byte, tx_valid, tx_ready byte handshake towards uart_tx
//   busy                       high whenever not idle
//   rx_overflow, req_error     sticky error flags, cleared only by rst
module uart_io_responder #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_renable,
   input  logic [1:0]  uart_rsz,
   output logic [31:0] uart_rd,
   output logic        uart_rdone,
   input  logic        uart_wenable,
   input  logic [1:0]  uart_wsz,
   input  logic [31:0] uart_wd,
   output logic        uart_wdone,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        rx_overflow,
   output logic        req_error
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] PtrOne = (FIFO_AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  sz_q, sz_d;     // size code: byte count minus one
   logic [1:0]  cnt_q, cnt_d;   // bytes already popped / handshaken
   logic [31:0] acc_q, acc_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] rd_q, rd_d;
   logic        is_rd_q, is_rd_d;
   logic        ovf_q, ovf_d;
   logic        err_q, err_d;

   // RX FIFO
   logic [7:0]       mem_q [Depth];
   logic [FIFO_AW:0] wptr_q, rptr_q;
   logic             fifo_empty, fifo_full;
   logic             push_valid, push, pop;
   logic [7:0]       push_data, pop_data;
   logic [1:0]       sel;

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                       (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign pop_data   = mem_q[rptr_q[FIFO_AW-1:0]];

`ifdef UART_IO_LOOPBACK_EN
   assign push_valid = tx_valid & tx_ready;
   assign push_data  = tx_byte;
`else
   assign push_valid = rx_valid;
   assign push_data  = rx_byte;
`endif

   // Fullness is judged before this cycle's pop, so a full FIFO drops the byte.
   assign push = push_valid & ~fifo_full;
   assign pop  = (state_q == StRd) & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[FIFO_AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PtrOne;
         if (pop)  rptr_q <= rptr_q + PtrOne;
      end
   end

   // Outputs
   assign sel         = sz_q - cnt_q;   // byte lane still to send, counted from lane 0
   assign busy        = (state_q != StIdle);
   assign tx_valid    = (state_q == StWr);
   assign tx_byte     = tx_valid ? wd_q[{sel, 3'b000} +: 8] : 8'h00;
   assign uart_rdone  = (state_q == StDone) & is_rd_q;
   assign uart_wdone  = (state_q == StDone) & ~is_rd_q;
   assign uart_rd     = rd_q;
   assign rx_overflow = ovf_q;
   assign req_error   = err_q;

   always_comb begin
      state_d = state_q;
      sz_d    = sz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      wd_d    = wd_q;
      rd_d    = rd_q;
      is_rd_d = is_rd_q;
      ovf_d   = ovf_q | (push_valid & fifo_full);
      err_d   = err_q;

      case (state_q)
         StIdle: begin
            if (uart_wenable) begin
               // A simultaneous read is dropped in favour of the write.
               wd_d    = uart_wd;
               sz_d    = uart_wsz;
               cnt_d   = 2'd0;
               is_rd_d = 1'b0;
               state_d = StWr;
               if (uart_renable) err_d = 1'b1;
            end else if (uart_renable) begin
               sz_d    = uart_rsz;
               cnt_d   = 2'd0;
               acc_d   = '0;
               is_rd_d = 1'b1;
               state_d = StRd;
            end
         end
         StRd: begin
            if (!fifo_empty) begin
               acc_d = {acc_q[23:0], pop_data};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == sz_q) begin
                  rd_d    = {acc_q[23:0], pop_data};
                  state_d = StDone;
               end
            end
         end
         StWr: begin
            if (tx_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == sz_q) state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if ((state_q != StIdle) && (uart_renable || uart_wenable)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sz_q    <= 2'd0;
         cnt_q   <= 2'd0;
         acc_q   <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         is_rd_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sz_q    <= sz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         is_rd_q <= is_rd_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_io_responder.sv
// Testbench for uart_io_responder: directed and randomized IN/OUT transfers checked
// against a byte-queue model of the RX buffer and the word/byte ordering rules.
module tb_uart_io_responder;

   localparam int unsigned FifoAw = 4;
   localparam int unsigned Depth  = 2 ** FifoAw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_renable = 1'b0;
   logic [1:0]  uart_rsz = 2'd0;
   logic [31:0] uart_rd;
   logic        uart_rdone;
   logic        uart_wenable = 1'b0;
   logic [1:0]  uart_wsz = 2'd0;
   logic [31:0] uart_wd = 32'd0;
   logic        uart_wdone;
   logic [7:0]  rx_byte = 8'd0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        rx_overflow;
   logic        req_error;

   uart_io_responder #(.FIFO_AW(FifoAw)) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_renable (uart_renable),
      .uart_rsz     (uart_rsz),
      .uart_rd      (uart_rd),
      .uart_rdone   (uart_rdone),
      .uart_wenable (uart_wenable),
      .uart_wsz     (uart_wsz),
      .uart_wd      (uart_wd),
      .uart_wdone   (uart_wdone),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .tx_byte      (tx_byte),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .rx_overflow  (rx_overflow),
      .req_error    (req_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model of the RX buffer: ordered bytes plus sticky overflow.
   logic [7:0] model_q[$];
   bit         model_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [7:0] b);
      if (model_q.size() < Depth) model_q.push_back(b);
      else model_ovf = 1'b1;
   endtask

   task automatic model_pop(input int n, output logic [31:0] w);
      w = 32'd0;
      for (int i = 0; i < n; i++) begin
         w = (w << 8) | {24'd0, model_q.pop_front()};
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      step();
      rx_valid = 1'b0;
`ifndef UART_IO_LOOPBACK_EN
      model_push(b);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
   endtask

   // Issues an IN request now; returns the word and the cycle count to uart_rdone (0 = none).
   task automatic do_read(input logic [1:0] sz, output logic [31:0] data, output int lat);
      uart_renable = 1'b1;
      uart_rsz     = sz;
      step();
      uart_renable = 1'b0;
      lat = 0;
      for (int i = 1; i <= 64; i++) begin
         if (uart_rdone) begin
            lat = i;
            break;
         end
         step();
      end
      data = uart_rd;
   endtask

   // Issues an OUT request now and runs handshakes with tx_ready random at ready_pct percent.
   // sent collects handshake bytes, first one most significant.
   task automatic do_write(input logic [1:0] sz, input logic [31:0] wd, input int ready_pct,
                           input bit also_rd, output bit done, output int nhs,
                           output logic [31:0] sent, output int stall_bad,
                           output int rdone_seen);
      bit         prev_stalled;
      logic [7:0] prev_byte;
      prev_stalled = 1'b0;
      prev_byte    = 8'd0;
      done         = 1'b0;
      nhs          = 0;
      sent         = 32'd0;
      stall_bad    = 0;
      rdone_seen   = 0;
      uart_wenable = 1'b1;
      uart_wsz     = sz;
      uart_wd      = wd;
      uart_renable = also_rd;
      uart_rsz     = 2'd2;
      step();
      uart_wenable = 1'b0;
      uart_renable = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tx_ready = ($urandom_range(0, 99) < ready_pct);
         if (uart_wdone) done = 1'b1;
         if (uart_rdone) rdone_seen++;
         if (tx_valid) begin
            if (prev_stalled && tx_byte !== prev_byte) stall_bad++;
            if (tx_ready) begin
               nhs++;
               sent = {sent[23:0], tx_byte};
`ifdef UART_IO_LOOPBACK_EN
               model_push(tx_byte);
`endif
            end
            prev_stalled = !tx_ready;
            prev_byte    = tx_byte;
         end else begin
            prev_stalled = 1'b0;
         end
         if (!done) step();
      end
      tx_ready = 1'b0;
   endtask

   function automatic logic [31:0] low_bytes(input logic [31:0] w, input logic [1:0] sz);
      if (sz == 2'd3) return w;
      return w & ((32'd1 << (8 * (int'(sz) + 1))) - 32'd1);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] data, exp;
      int          lat, nhs, stall_bad, rdone_seen, bad;
      bit          done;
      logic [1:0]  sz;

      do_reset();
      check("reset_rd", uart_rd, 32'd0);
      check("reset_rdone", {31'd0, uart_rdone}, 32'd0);
      check("reset_wdone", {31'd0, uart_wdone}, 32'd0);
      check("reset_tx", {23'd0, tx_valid, tx_byte}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_flags", {30'd0, rx_overflow, req_error}, 32'd0);

`ifdef UART_IO_LOOPBACK_EN
      do_write(2'd3, 32'hCAFEF00D, 100, 1'b0, done, nhs, data, stall_bad, rdone_seen);
      check("lb_wdone", {31'd0, done}, 32'd1);
      check("lb_sent", data, 32'hCAFEF00D);
      step();
      do_read(2'd3, data, lat);
      model_pop(4, exp);
      check("lb_rd", data, exp);
      check("lb_rd_fixed", data, 32'hCAFEF00D);
      check("lb_lat", lat, 32'd5);
      check("lb_ovf", {31'd0, rx_overflow}, {31'd0, model_ovf});
      check("lb_err", {31'd0, req_error}, 32'd0);
`else
      // Four buffered bytes, IN of four: exact latency and busy window.
      push_byte(8'h12);
      push_byte(8'h34);
      push_byte(8'h56);
      push_byte(8'h78);
      check("rd4_busy_T", {31'd0, busy}, 32'd0);
      uart_renable = 1'b1;
      uart_rsz     = 2'd3;
      step();
      uart_renable = 1'b0;
      bad = 0;
      for (int i = 1; i <= 4; i++) begin
         if (!busy || uart_rdone) bad++;
         step();
      end
      check("rd4_wait_window", bad, 32'd0);
      check("rd4_rdone_T5", {31'd0, uart_rdone}, 32'd1);
      check("rd4_busy_T5", {31'd0, busy}, 32'd1);
      model_pop(4, exp);
      check("rd4_data", uart_rd, exp);
      check("rd4_data_fixed", uart_rd, 32'h12345678);
      step();
      check("rd4_idle_after", {30'd0, busy, uart_rdone}, 32'd0);
      check("rd4_hold", uart_rd, 32'h12345678);

      // IN of one byte with empty FIFO: waits, then completes two cycles after the push.
      uart_renable = 1'b1;
      uart_rsz     = 2'd0;
      step();
      uart_renable = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!busy || uart_rdone) bad++;
         step();
      end
      check("rd_empty_waits", bad, 32'd0);
      rx_valid = 1'b1;
      rx_byte  = 8'hAB;
      step();
      rx_valid = 1'b0;
      model_push(8'hAB);
      check("rd_empty_no_early", {31'd0, uart_rdone}, 32'd0);
      step();
      check("rd_empty_rdone", {31'd0, uart_rdone}, 32'd1);
      model_pop(1, exp);
      check("rd_empty_data", uart_rd, exp);
      step();

      // OUT of two bytes with tx_ready low three cycles.
      tx_ready     = 1'b0;
      uart_wenable = 1'b1;
      uart_wsz     = 2'd1;
      uart_wd      = 32'hDEADBEEF;
      step();
      uart_wenable = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (!tx_valid || tx_byte !== 8'hBE) bad++;
         step();
      end
      check("wr_stall_hold", bad, 32'd0);
      tx_ready = 1'b1;
      check("wr_byte0", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, 8'hBE});
      step();
      check("wr_byte1", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, 8'hEF});
      check("wr_no_early_done", {31'd0, uart_wdone}, 32'd0);
      step();
      tx_ready = 1'b0;
      check("wr_wdone", {30'd0, uart_wdone, tx_valid}, 32'd2);
      step();

      // Randomized OUT transfers.
      for (int it = 0; it < 6; it++) begin
         sz = 2'($urandom_range(0, 3));
         exp = $urandom;
         do_write(sz, exp, 50, 1'b0, done, nhs, data, stall_bad, rdone_seen);
         check("rwr_done", {31'd0, done}, 32'd1);
         check("rwr_count", nhs, int'(sz) + 1);
         check("rwr_bytes", data, low_bytes(exp, sz));
         check("rwr_stable", stall_bad + rdone_seen, 32'd0);
         step();
      end

      // Randomized IN transfers from a pre-filled FIFO.
      for (int it = 0; it < 6; it++) begin
         sz = 2'($urandom_range(0, 3));
         for (int j = 0; j < int'(sz) + 1 + $urandom_range(0, 1); j++) begin
            push_byte(8'($urandom));
         end
         do_read(sz, data, lat);
         model_pop(int'(sz) + 1, exp);
         check("rrd_data", data, exp);
         check("rrd_latency", lat, int'(sz) + 2);
         step();
      end
      check("rrd_no_ovf", {31'd0, rx_overflow}, {31'd0, model_ovf});

      // Overflow at exactly Depth+1 pushes; the oldest bytes survive.
      do_reset();
      for (int j = 0; j < Depth; j++) push_byte(8'($urandom));
      check("ovf_full_clear", {31'd0, rx_overflow}, 32'd0);
      push_byte(8'($urandom));
      check("ovf_set", {31'd0, rx_overflow}, {31'd0, model_ovf});
      check("ovf_set_fixed", {31'd0, rx_overflow}, 32'd1);
      do_read(2'd3, data, lat);
      model_pop(4, exp);
      check("ovf_first4", data, exp);
      check("ovf_latency", lat, 32'd5);
      step();

      // Both strobes together: only the write proceeds.
      do_reset();
      do_write(2'd0, 32'h00000041, 100, 1'b1, done, nhs, data, stall_bad, rdone_seen);
      for (int i = 0; i < 8; i++) begin
         step();
         if (uart_rdone) rdone_seen++;
      end
      check("both_wdone", {31'd0, done}, 32'd1);
      check("both_count", nhs, 32'd1);
      check("both_byte", data, 32'h00000041);
      check("both_no_rdone", rdone_seen, 32'd0);
      check("both_err", {31'd0, req_error}, 32'd1);
      do_reset();
      check("err_cleared", {30'd0, req_error, rx_overflow}, 32'd0);

      // Strobe while busy: flagged and ignored.
      push_byte(8'h5A);
      push_byte(8'hC3);
      uart_renable = 1'b1;
      uart_rsz     = 2'd1;
      step();
      uart_renable = 1'b0;
      uart_wenable = 1'b1;
      uart_wsz     = 2'd0;
      uart_wd      = 32'h55;
      tx_ready     = 1'b1;
      step();
      uart_wenable = 1'b0;
      bad = 0;
      lat = 0;
      for (int i = 2; i <= 12; i++) begin
         if (tx_valid || uart_wdone) bad++;
         if (uart_rdone && lat == 0) lat = i;
         step();
      end
      tx_ready = 1'b0;
      model_pop(2, exp);
      check("busy_strobe_rd", uart_rd, exp);
      check("busy_strobe_lat", lat, 32'd3);
      check("busy_strobe_nowr", bad, 32'd0);
      check("busy_strobe_err", {31'd0, req_error}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
